// File: rtl/iomem_pkg.sv
// iomem_pkg: shared state encoding, default window constants and strobe helper
// for the iomem program loader.
package iomem_pkg;
  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE, S_ERROR} state_t;
  localparam logic [31:0] DEF_BASE_ADDR = 32'h4000_0000;
  localparam logic [31:0] DEF_ADDR_MASK = 32'h000f_ffff;
  localparam int DEF_TIMEOUT_CYCLES = 64;
  // Lane count modulo 4: a wrapped count of 0 means a full word.
  function automatic logic [3:0] wstrb_from_count(input logic [1:0] n);
    return n == 2'd1 ? 4'b0001 : n == 2'd2 ? 4'b0011 : n == 2'd3 ? 4'b0111 : 4'b1111;
  endfunction
endpackage

// File: rtl/iomem_word_packer.sv
// iomem_word_packer: assembles little-endian 32-bit words from a byte stream
// and derives the write strobes for the held word.
module iomem_word_packer
  import iomem_pkg::*;
(
  input  logic        clk_used,
  input  logic        rst_n,
  input  logic        i_clear,
  input  logic        i_accept,
  input  logic        i_last,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic [3:0]  o_strb,
  output logic        o_word_done
);
  logic [31:0] r_data;
  logic [1:0]  r_lane;
  always_ff @(posedge clk_used) begin
    if (!rst_n || i_clear) begin
      r_data <= '0;
      r_lane <= '0;
    end else if (i_accept) begin
      r_data[{r_lane, 3'b000} +: 8] <= i_byte;
      r_lane <= r_lane + 2'd1;
    end
  end
  assign o_word      = r_data;
  assign o_strb      = wstrb_from_count(r_lane);
  assign o_word_done = i_accept && (r_lane == 2'd3 || i_last);
endmodule

// File: rtl/iomem_prog_loader.sv
// iomem_prog_loader: packs a byte stream into words and writes them to
// consecutive iomem addresses, tracking checksum, word count and bus timeout.
module iomem_prog_loader
  import iomem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = DEF_BASE_ADDR,
  parameter logic [31:0] ADDR_MASK      = DEF_ADDR_MASK,
  parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic        clk_used,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [20:0] length_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        byte_ready_o,
  output logic        iomem_valid_o,
  input  logic        iomem_ready_i,
  output logic [3:0]  iomem_wstrb_o,
  output logic [31:0] iomem_addr_o,
  output logic [31:0] iomem_wdata_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [31:0] checksum_o,
  output logic [18:0] words_written_o
);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [32:0] MAX_LEN = {1'b0, ADDR_MASK} + 33'd1;
  state_t      r_state;
  logic [20:0] r_remaining;
  logic        r_valid;
  logic [31:0] r_addr, r_wdata, r_checksum;
  logic [3:0]  r_wstrb;
  logic [18:0] r_words;
  logic [TMO_W-1:0] r_tmo;
  logic        w_busy, w_start_ok, w_accept, w_complete, w_word_done;
  logic [31:0] w_word;
  logic [3:0]  w_strb;
  assign w_busy     = r_state == S_COLLECT || r_state == S_WRITE;
  assign w_start_ok = start_i && !w_busy;
  assign w_accept   = r_state == S_COLLECT && byte_valid_i;
  assign w_complete = r_state == S_WRITE && r_valid && iomem_ready_i;
  iomem_word_packer u_packer (
    .clk_used    (clk_used),
    .rst_n       (rst_n),
    .i_clear     (w_start_ok || w_complete),
    .i_accept    (w_accept),
    .i_last      (r_remaining == 21'd1),
    .i_byte      (byte_data_i),
    .o_word      (w_word),
    .o_strb      (w_strb),
    .o_word_done (w_word_done)
  );
  always_ff @(posedge clk_used) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_valid     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_checksum  <= '0;
      r_words     <= '0;
      r_tmo       <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: if (start_i) begin
          r_checksum  <= '0;
          r_words     <= '0;
          r_remaining <= length_i;
          r_state     <= length_i == 21'd0 ? S_DONE :
                         {12'd0, length_i} > MAX_LEN ? S_ERROR : S_COLLECT;
        end
        S_COLLECT: if (w_accept) begin
          r_remaining <= r_remaining - 21'd1;
          if (w_word_done) begin
            r_state <= S_WRITE;
            r_tmo   <= '0;
          end
        end
        S_WRITE: begin
          // Request launches one cycle after entry; ready beats the timeout.
          if (!r_valid) begin
            r_valid <= 1'b1;
            r_addr  <= BASE_ADDR + {11'd0, r_words, 2'b00};
            r_wdata <= w_word;
            r_wstrb <= w_strb;
          end else if (iomem_ready_i) begin
            r_valid    <= 1'b0;
            r_checksum <= r_checksum + r_wdata;
            r_words    <= r_words + 19'd1;
            r_state    <= r_remaining == 21'd0 ? S_DONE : S_COLLECT;
          end else if (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            r_valid <= 1'b0;
            r_state <= S_ERROR;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign byte_ready_o    = r_state == S_COLLECT;
  assign busy_o          = w_busy;
  assign done_o          = r_state == S_DONE;
  assign error_o         = r_state == S_ERROR;
  assign iomem_valid_o   = r_valid;
  assign iomem_addr_o    = r_addr;
  assign iomem_wdata_o   = r_wdata;
  assign iomem_wstrb_o   = r_wstrb;
  assign checksum_o      = r_checksum;
  assign words_written_o = r_words;
endmodule

// File: tb/tb_iomem_prog_loader.sv
// tb_iomem_prog_loader: scoreboard bench feeding bytes and acting as the
// iomem responder with configurable ready latency.
module tb_iomem_prog_loader;
  typedef struct packed {logic [31:0] a; logic [31:0] d; logic [3:0] s;} txn_t;
  logic        clk_used = 1'b0, rst_n = 1'b0, start_i = 1'b0;
  logic [20:0] length_i = '0;
  logic        byte_valid_i = 1'b0, iomem_ready_i = 1'b0;
  logic [7:0]  byte_data_i = '0;
  logic        byte_ready_o, iomem_valid_o, busy_o, done_o, error_o;
  logic [3:0]  iomem_wstrb_o;
  logic [31:0] iomem_addr_o, iomem_wdata_o, checksum_o;
  logic [18:0] words_written_o;
  txn_t        exp_q[$];
  logic [7:0]  feed_q[$];
  int          n_cmp = 0, n_bad = 0, n_valid_cyc = 0;

  iomem_prog_loader dut (
    .clk_used(clk_used), .rst_n(rst_n), .start_i(start_i), .length_i(length_i),
    .byte_valid_i(byte_valid_i), .byte_data_i(byte_data_i), .byte_ready_o(byte_ready_o),
    .iomem_valid_o(iomem_valid_o), .iomem_ready_i(iomem_ready_i), .iomem_wstrb_o(iomem_wstrb_o),
    .iomem_addr_o(iomem_addr_o), .iomem_wdata_o(iomem_wdata_o), .busy_o(busy_o),
    .done_o(done_o), .error_o(error_o), .checksum_o(checksum_o), .words_written_o(words_written_o)
  );

  always #5 clk_used = ~clk_used;
  always @(negedge clk_used) if (iomem_valid_o) n_valid_cyc++;
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic do_start(input logic [20:0] len);
    @(negedge clk_used);
    start_i = 1'b1;
    length_i = len;
    @(negedge clk_used);
    start_i = 1'b0;
  endtask

  task automatic feed_bytes();
    int w;
    while (feed_q.size() > 0) begin
      w = 0;
      byte_valid_i = 1'b1;
      byte_data_i = feed_q[0];
      while (!byte_ready_o && w < 2000) begin
        @(negedge clk_used);
        w++;
      end
      if (w >= 2000) begin
        n_cmp++; n_bad++;
        $display("FAIL feed_stall got=byte_ready low exp=byte accepted");
        feed_q.delete();
      end else begin
        void'(feed_q.pop_front());
        @(negedge clk_used);
      end
    end
    byte_valid_i = 1'b0;
  endtask

  task automatic respond(input int nwords, input int dly);
    int w;
    txn_t got, e;
    for (int i = 0; i < nwords; i++) begin
      w = 0;
      while (!iomem_valid_o && w < 2000) begin
        @(negedge clk_used);
        w++;
      end
      if (w >= 2000) begin
        n_cmp++; n_bad++;
        $display("FAIL resp_wait got=valid low exp=valid high");
        return;
      end
      got = {iomem_addr_o, iomem_wdata_o, iomem_wstrb_o};
      e = '0;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL resp_txn got=%h exp=%h", got, e);
      end
      for (int k = 1; k < dly; k++) begin
        @(negedge clk_used);
        n_cmp++;
        if ({iomem_addr_o, iomem_wdata_o, iomem_wstrb_o, iomem_valid_o, byte_ready_o} !== {got, 1'b1, 1'b0}) begin
          n_bad++;
          $display("FAIL resp_hold cyc=%0d got=%h/%b/%b exp=%h/1/0", k,
                   {iomem_addr_o, iomem_wdata_o, iomem_wstrb_o}, iomem_valid_o, byte_ready_o, got);
        end
      end
      iomem_ready_i = 1'b1;
      @(negedge clk_used);
      iomem_ready_i = 1'b0;
      n_cmp++;
      if (iomem_valid_o !== 1'b0) begin
        n_bad++;
        $display("FAIL valid_drop got=%b exp=0", iomem_valid_o);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_used);
    n_cmp++;
    if ({byte_ready_o, iomem_valid_o, iomem_wstrb_o, iomem_addr_o, iomem_wdata_o, busy_o, done_o, error_o, checksum_o, words_written_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got=%b/%b/%h/%h/%h/%b%b%b/%h/%0d exp=all zero", byte_ready_o, iomem_valid_o,
               iomem_wstrb_o, iomem_addr_o, iomem_wdata_o, busy_o, done_o, error_o, checksum_o, words_written_o);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_full_words();
    exp_q.push_back({32'h4000_0000, 32'h0403_0201, 4'b1111});
    exp_q.push_back({32'h4000_0004, 32'h0807_0605, 4'b1111});
    feed_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    do_start(21'd8);
    fork feed_bytes(); respond(2, 1); join
    n_cmp++;
    if ({done_o, busy_o, error_o, checksum_o, words_written_o} !== {3'b100, 32'h0C0A_0806, 19'd2}) begin
      n_bad++;
      $display("FAIL full_words_end got=%b%b%b/%h/%0d exp=100/0c0a0806/2", done_o, busy_o, error_o, checksum_o, words_written_o);
    end
  endtask

  task automatic test_partial();
    exp_q.push_back({32'h4000_0000, 32'hDDCC_BBAA, 4'b1111});
    exp_q.push_back({32'h4000_0004, 32'h0000_00EE, 4'b0001});
    feed_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    do_start(21'd5);
    n_cmp++;
    if ({busy_o, byte_ready_o, done_o} !== 3'b110) begin
      n_bad++;
      $display("FAIL partial_collect got=%b%b%b exp=110", busy_o, byte_ready_o, done_o);
    end
    fork feed_bytes(); respond(2, 1); join
    n_cmp++;
    if ({done_o, checksum_o, words_written_o} !== {1'b1, 32'hDDCC_BC98, 19'd2}) begin
      n_bad++;
      $display("FAIL partial_end got=%b/%h/%0d exp=1/ddccbc98/2", done_o, checksum_o, words_written_o);
    end
  endtask

  task automatic test_slow_responder();
    exp_q.push_back({32'h4000_0000, 32'h4433_2211, 4'b1111});
    exp_q.push_back({32'h4000_0004, 32'h0000_6655, 4'b0011});
    feed_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    do_start(21'd6);
    fork feed_bytes(); respond(2, 16); join
    n_cmp++;
    if ({done_o, checksum_o, words_written_o} !== {1'b1, 32'h4433_8866, 19'd2}) begin
      n_bad++;
      $display("FAIL slow_end got=%b/%h/%0d exp=1/44338866/2", done_o, checksum_o, words_written_o);
    end
  endtask

  task automatic test_ready_boundary();
    exp_q.push_back({32'h4000_0000, 32'h7856_3412, 4'b1111});
    feed_q = '{8'h12, 8'h34, 8'h56, 8'h78};
    do_start(21'd4);
    fork feed_bytes(); respond(1, 64); join
    n_cmp++;
    if ({done_o, error_o, words_written_o} !== {2'b10, 19'd1}) begin
      n_bad++;
      $display("FAIL ready_boundary got=%b%b/%0d exp=10/1", done_o, error_o, words_written_o);
    end
  endtask

  task automatic test_timeout();
    int cnt, w;
    feed_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    do_start(21'd4);
    feed_bytes();
    w = 0;
    while (!iomem_valid_o && w < 100) begin
      @(negedge clk_used);
      w++;
    end
    cnt = 0;
    while (iomem_valid_o && cnt < 200) begin
      cnt++;
      @(negedge clk_used);
    end
    n_cmp++;
    if (cnt !== 64) begin
      n_bad++;
      $display("FAIL timeout_cycles got=%0d exp=64", cnt);
    end
    n_cmp++;
    if ({error_o, done_o, busy_o, iomem_valid_o, words_written_o} !== {4'b1000, 19'd0}) begin
      n_bad++;
      $display("FAIL timeout_state got=%b%b%b%b/%0d exp=1000/0", error_o, done_o, busy_o, iomem_valid_o, words_written_o);
    end
  endtask

  task automatic test_zero_and_oversize();
    int v0;
    v0 = n_valid_cyc;
    do_start(21'd0);
    n_cmp++;
    if ({done_o, error_o, busy_o} !== 3'b100) begin
      n_bad++;
      $display("FAIL zero_len got=%b%b%b exp=100", done_o, error_o, busy_o);
    end
    do_start(21'h10_0001);
    n_cmp++;
    if ({done_o, error_o, busy_o, byte_ready_o} !== 4'b0100) begin
      n_bad++;
      $display("FAIL oversize got=%b%b%b%b exp=0100", done_o, error_o, busy_o, byte_ready_o);
    end
    repeat (5) @(negedge clk_used);
    n_cmp++;
    if (n_valid_cyc !== v0) begin
      n_bad++;
      $display("FAIL no_bus_activity got=%0d exp=%0d", n_valid_cyc, v0);
    end
  endtask

  task automatic test_reset_mid_write();
    int w;
    feed_q = '{8'hC0, 8'hFF, 8'hEE, 8'h15};
    do_start(21'd4);
    feed_bytes();
    w = 0;
    while (!iomem_valid_o && w < 100) begin
      @(negedge clk_used);
      w++;
    end
    n_cmp++;
    if (iomem_valid_o !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_valid got=%b exp=1", iomem_valid_o);
    end
    rst_n = 1'b0;
    @(negedge clk_used);
    n_cmp++;
    if ({byte_ready_o, iomem_valid_o, iomem_wstrb_o, iomem_addr_o, iomem_wdata_o, busy_o, done_o, error_o, checksum_o, words_written_o} !== '0) begin
      n_bad++;
      $display("FAIL mid_reset got=%b/%h/%h/%b%b%b exp=all zero", iomem_valid_o, iomem_addr_o, iomem_wdata_o, busy_o, done_o, error_o);
    end
    rst_n = 1'b1;
    exp_q.push_back({32'h4000_0000, 32'h0D0C_0B0A, 4'b1111});
    feed_q = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
    do_start(21'd4);
    fork feed_bytes(); respond(1, 2); join
    n_cmp++;
    if ({done_o, checksum_o, words_written_o} !== {1'b1, 32'h0D0C_0B0A, 19'd1}) begin
      n_bad++;
      $display("FAIL post_reset_load got=%b/%h/%0d exp=1/0d0c0b0a/1", done_o, checksum_o, words_written_o);
    end
  endtask

  initial begin
    test_reset();
    test_full_words();
    test_partial();
    test_slow_responder();
    test_ready_boundary();
    test_timeout();
    test_zero_and_oversize();
    test_reset_mid_write();
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_bad++;
      $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/iomem_prog_loader.md
Name: iomem_prog_loader

Overview:
Byte-stream program loader acting as the initiator on the iomem valid/ready bus, the counterpart of the main-memory responder. It accepts a byte stream (for example from a UART receiver) and packs it into little-endian 32-bit words. Each word is written to consecutive main-memory addresses starting at BASE_ADDR. It reports completion, a running 32-bit word checksum, and a bus-timeout error.

Parameters:
BASE_ADDR, 32'h4000_0000, address of the first word written
ADDR_MASK, 32'h000f_ffff, RAM window mask; max load = ADDR_MASK+1 bytes
TIMEOUT_CYCLES, 64, max cycles iomem_valid_o may wait for iomem_ready_i

Ports:
clk_used  in  1  clock
rst_n  in  1  reset: synchronous, active-low; clock clk_used
start_i  in  1  pulse: begin a load (ignored unless IDLE/DONE/ERROR)
length_i  in  21  byte count, latched on accepted start_i
byte_valid_i  in  1  input byte valid
byte_data_i  in  8  input byte
byte_ready_o  out  1  byte accepted when valid&&ready
iomem_valid_o  out  1  bus request
iomem_ready_i  in  1  bus response
iomem_wstrb_o  out  4  byte strobes
iomem_addr_o  out  32  word address
iomem_wdata_o  out  32  write data
busy_o  out  1  load in progress
done_o  out  1  level: load completed, held until next start
error_o  out  1  level: timeout or oversize, held until next start
checksum_o  out  32  sum mod 2^32 of all written words (padding = 0)
words_written_o  out  19  count of completed bus writes

Behaviour:
- Reset: all outputs 0 (addr/wdata/wstrb 0); state IDLE; byte lane index 0.
- States: IDLE, COLLECT, WRITE, DONE, ERROR.
- IDLE/DONE/ERROR + start_i:
  - Clear done, error, checksum, words_written.
  - length_i==0 -> DONE.
  - length_i > ADDR_MASK+1 -> ERROR; no bus activity.
  - Otherwise -> COLLECT.
- COLLECT:
  - byte_ready_o=1. Byte k of a word goes to bits [8k+7:8k].
  - Move to WRITE when 4 bytes are collected, or when the last byte of length arrives.
- Partial final word: unused lanes are 0 and wstrb covers only the valid lanes (1 byte->0001, 2->0011, 3->0111). Full words use 1111.
- WRITE:
  - byte_ready_o=0. iomem_valid_o is registered: high the cycle after entering WRITE.
  - addr = BASE_ADDR + 4*word_index.
  - valid/addr/wdata/wstrb stay stable until the cycle iomem_ready_i is sampled high with valid high.
  - On completion: valid drops next cycle, checksum += wdata, words_written++.
  - Then -> DONE if all bytes are written, else -> COLLECT.
  - Back-to-back writes: valid is low for at least 1 cycle between transactions.
- Timeout: the counter resets on entering WRITE and increments each cycle valid=1 and ready=0. When it reaches TIMEOUT_CYCLES: ERROR, valid low next cycle, the word is not counted.
- ready together with counter==TIMEOUT_CYCLES-1: ready wins.
- busy_o=1 in COLLECT and WRITE.
- start_i while busy is ignored.
- iomem_ready_i while valid low is ignored.
- Reset mid-operation (any state): returns to IDLE, valid low from the next edge, partial word discarded.

Decomposition:
- Package iomem_pkg:
  - state enum
  - BASE_ADDR/ADDR_MASK defaults
  - wstrb-from-byte-count function
- Sub-module iomem_word_packer:
  - byte lane index, 32-bit assembly register, strobe generation
  - "word ready" / "last" flags
- FSM, timeout counter and checksum stay in the top module.

Test Plan:
- length=8, bytes 01..08, ready 1 cycle after valid -> writes {0x4000_0000, 0x04030201, 1111}, {0x4000_0004, 0x08070605, 1111}; checksum 0x0C0A0806; words_written 2; done_o=1.
- length=5, bytes AA BB CC DD EE -> second write addr 0x4000_0004, wdata 0x000000EE, wstrb 0001; checksum 0xDDCCBBAA+0xEE = 0xDDCCBC98.
- Responder with 16-cycle ready delay -> valid/addr/wdata stable for all 16 cycles; byte_ready_o=0 throughout; no bytes lost.
- ready never asserted -> error_o=1 after exactly 64 waiting cycles; valid low next cycle; words_written 0; next start clears error.
- length=0 -> done_o next cycle, no transactions. length=0x100001 -> error_o, no transactions.
- rst_n low during WRITE with valid high -> valid=0 and all outputs 0 after the edge; new start with length=4 completes normally at 0x4000_0000.
